// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESS    = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROW_IDLE  = 4'hF;

    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } row_hit_t;

    // Valid only when exactly one row line is low; idx is that row.
    function automatic row_hit_t onehot0_low(input logic [3:0] row);
        row_hit_t hit;
        hit.vld = 1'b0;
        hit.idx = 2'd0;
        case (row)
            4'b1110: begin hit.vld = 1'b1; hit.idx = 2'd0; end
            4'b1101: begin hit.vld = 1'b1; hit.idx = 2'd1; end
            4'b1011: begin hit.vld = 1'b1; hit.idx = 2'd2; end
            4'b0111: begin hit.vld = 1'b1; hit.idx = 2'd3; end
            default: begin hit.vld = 1'b0; hit.idx = 2'd0; end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Latency: 2 clk cycles from row input to row_s.
// Backpressure: none; samples every cycle.
module key_sync2
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] row_s
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two-stage capture; resets to "no key" so nothing looks pressed at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ROW_IDLE;
            sync_q <= ROW_IDLE;
        end else begin
            meta_q <= row;
            sync_q <= meta_q;
        end
    end

    assign row_s = sync_q;

endmodule

// File: rtl/keypad_scan_db.sv
// 4x4 keypad column scanner with debounce; one flag pulse per accepted press.
// Latency: 2 sync + up to COL_CYCLES dwell + DB_CYCLES debounce + 1 to flag.
// Backpressure: none; flag is a one-cycle pulse, data holds last code.
module keypad_scan_db
    import keypad_pkg::*;
#(
    parameter int COL_CYCLES = 50_000,
    parameter int DB_CYCLES  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       flag,
    output logic [3:0] data
);

    localparam int MAX_CYC = (COL_CYCLES > DB_CYCLES) ? COL_CYCLES : DB_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       row_s;
    state_t           state_q, state_d;
    logic [1:0]       c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       row_lat_q, row_lat_d;
    logic             flag_q, flag_d;
    logic [3:0]       data_q, data_d;
    row_hit_t         hit;

    key_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .row   (row),
        .row_s (row_s)
    );

    assign hit = onehot0_low(row_lat_q);

    // State, shared counter, column index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            c_q       <= 2'd0;
            cnt_q     <= '0;
            row_lat_q <= ROW_IDLE;
            flag_q    <= 1'b0;
            data_q    <= 4'h0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            row_lat_q <= row_lat_d;
            flag_q    <= flag_d;
            data_q    <= data_d;
        end
    end

    // Next-state: flag is raised on entry to PRESS so it is high exactly while in PRESS.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        cnt_d     = cnt_q + CNT_W'(1);
        row_lat_d = row_lat_q;
        flag_d    = 1'b0;
        data_d    = data_q;
        case (state_q)
            SCAN: begin
                if (cnt_q == COL_LAST) begin
                    cnt_d = '0;
                    if (row_s != ROW_IDLE) begin
                        row_lat_d = row_s;
                        state_d   = DEBOUNCE;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (row_s != row_lat_q) begin
                    // Rows moved during the window: treat as bounce, rescan this column.
                    cnt_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d = '0;
                    if (hit.vld) begin
                        flag_d  = 1'b1;
                        data_d  = {hit.idx, c_q};
                        state_d = PRESS;
                    end else begin
                        // Multiple rows low (multi-key or ghost): swallow silently.
                        state_d = WAIT_REL;
                    end
                end
            end
            PRESS: begin
                cnt_d   = '0;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (row_s != ROW_IDLE) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d   = '0;
                    c_d     = c_q + 2'd1;
                    state_d = SCAN;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
    end

    assign col  = ~(4'(1) << c_q);
    assign flag = flag_q;
    assign data = data_q;

endmodule

// File: tb/tb_keypad_scan_db.sv
// Directed bench for keypad_scan_db with a combinational keypad matrix model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_keypad_scan_db;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       flag;
    logic [3:0] data;

    logic [3:0][3:0] pressed;   // pressed[r][c]

    int n_chk;
    int n_pass;
    int flag_cnt;
    int dbl_cnt;
    logic [3:0] last_data;
    logic       prev_flag;

    keypad_scan_db #(
        .COL_CYCLES (4),
        .DB_CYCLES  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row   (row),
        .col   (col),
        .flag  (flag),
        .data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a closed key sits in a driven (low) column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = ~(|(pressed[r] & ~col));
        end
    end

    // Flag monitor: counts pulses, captures code, and spots pulses longer than one cycle.
    always @(negedge clk) begin
        if (flag) begin
            flag_cnt  = flag_cnt + 1;
            last_data = data;
            if (prev_flag) dbl_cnt = dbl_cnt + 1;
        end
        prev_flag = flag;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    int         fc;
    logic [3:0] col_a;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        flag_cnt  = 0;
        dbl_cnt   = 0;
        last_data = 4'h0;
        prev_flag = 1'b0;
        pressed   = '0;
        rst_n     = 1'b0;

        // Reset state
        #1;
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_flag", 32'(flag), 32'h0);
        chk("rst_data", 32'(data), 32'h0);

        // Release reset and watch the column rotate every 4 cycles
        step(3);
        rst_n = 1'b1;
        step(3);
        chk("rot0", 32'(col), 32'hE);
        step(1);
        chk("rot1", 32'(col), 32'hD);
        step(4);
        chk("rot2", 32'(col), 32'hB);
        step(4);
        chk("rot3", 32'(col), 32'h7);
        step(4);
        chk("rot4", 32'(col), 32'hE);

        // Single press r1c2
        fc = flag_cnt;
        pressed[1][2] = 1'b1;
        step(60);
        pressed[1][2] = 1'b0;
        chk("single_cnt", 32'(flag_cnt - fc), 32'd1);
        chk("single_data", 32'(last_data), 32'h6);
        step(14);
        chk("single_hold_col", 32'(col), 32'hB);
        step(6);
        chk("single_next_col", 32'(col), 32'h7);
        step(20);

        // Bouncing contact on r0c0: never stable long enough
        fc = flag_cnt;
        for (int i = 0; i < 8; i++) begin
            pressed[0][0] = ~pressed[0][0];
            step(5);
        end
        pressed[0][0] = 1'b0;
        step(30);
        chk("bounce_cnt", 32'(flag_cnt - fc), 32'd0);
        col_a = col;
        step(4);
        chk("bounce_scan", 32'(col), 32'(rotl(col_a)));

        // Long hold r3c3 gives a single flag
        fc = flag_cnt;
        pressed[3][3] = 1'b1;
        step(300);
        pressed[3][3] = 1'b0;
        chk("hold_cnt", 32'(flag_cnt - fc), 32'd1);
        chk("hold_data", 32'(last_data), 32'hF);
        step(20);

        // Re-press a different key r0c1
        fc = flag_cnt;
        pressed[0][1] = 1'b1;
        step(40);
        pressed[0][1] = 1'b0;
        chk("repress_cnt", 32'(flag_cnt - fc), 32'd1);
        chk("repress_data", 32'(last_data), 32'h1);
        step(30);

        // Two keys in one column: rejected, data keeps its value
        fc = flag_cnt;
        pressed[0][1] = 1'b1;
        pressed[2][1] = 1'b1;
        step(60);
        pressed[0][1] = 1'b0;
        pressed[2][1] = 1'b0;
        chk("multi_cnt", 32'(flag_cnt - fc), 32'd0);
        chk("multi_data", 32'(data), 32'h1);
        step(30);
        col_a = col;
        step(4);
        chk("multi_scan", 32'(col), 32'(rotl(col_a)));

        // Reset during WAIT_REL with r2c0 held; key re-detected afterwards
        fc = flag_cnt;
        pressed[2][0] = 1'b1;
        step(50);
        chk("mid_first_cnt", 32'(flag_cnt - fc), 32'd1);
        chk("mid_first_data", 32'(last_data), 32'h8);
        step(10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", 32'(col), 32'hE);
        chk("mid_rst_flag", 32'(flag), 32'h0);
        chk("mid_rst_data", 32'(data), 32'h0);
        step(2);
        rst_n = 1'b1;
        fc = flag_cnt;
        step(40);
        chk("mid_again_cnt", 32'(flag_cnt - fc), 32'd1);
        chk("mid_again_data", 32'(last_data), 32'h8);
        pressed[2][0] = 1'b0;
        step(30);

        chk("flag_width", 32'(dbl_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
